// File: rtl/mpu_seq_pkg.sv
// Shared sizing defaults, FSM state encoding and job descriptor for the
// MPU row sequencer.
package mpu_seq_pkg;

    localparam int DATA_WIDTH_DEF         = 8;
    localparam int SPARSE_INDEX_WIDTH_DEF = 4;
    localparam int ADDR_WIDTH_DEF         = 10;
    localparam int DIM_WIDTH_DEF          = 8;
    localparam int TIMEOUT_CYCLES_DEF     = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } seq_state_e;

    // Per-job fields the FSM needs after acceptance; the base addresses
    // live in the address generator.
    typedef struct packed {
        logic [DIM_WIDTH_DEF-1:0] rows;
        logic [DIM_WIDTH_DEF-1:0] depth;
        logic                     mode;
    } job_desc_t;

endpackage

// File: rtl/mpu_seq_addr_gen.sv
// Row and reduction-index counters plus activation/weight address generation.
// All address arithmetic wraps silently at 2^ADDR_WIDTH.
module mpu_seq_addr_gen
    import mpu_seq_pkg::*;
#(
    parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH          = DIM_WIDTH_DEF,
    parameter int SPARSE_INDEX_WIDTH = SPARSE_INDEX_WIDTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic                          k_adv_i,
    input  logic                          row_adv_i,
    input  logic [ADDR_WIDTH-1:0]         act_base_i,
    input  logic [ADDR_WIDTH-1:0]         wgt_base_i,
    input  logic [DIM_WIDTH-1:0]          rows_i,
    input  logic [DIM_WIDTH-1:0]          depth_i,
    output logic [ADDR_WIDTH-1:0]         act_addr_o,
    output logic [ADDR_WIDTH-1:0]         wgt_addr_o,
    output logic [SPARSE_INDEX_WIDTH-1:0] sparse_o,
    output logic [DIM_WIDTH-1:0]          row_o,
    output logic                          k_last_o,
    output logic                          row_last_o
);

    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] wgt_base_q, wgt_base_d;
    logic [DIM_WIDTH-1:0]  k_q, k_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d;

    // row_base tracks act_base + row*K incrementally, avoiding a multiplier.
    always_comb begin
        row_base_d = row_base_q;
        wgt_base_d = wgt_base_q;
        k_d        = k_q;
        row_d      = row_q;
        if (load_i) begin
            row_base_d = act_base_i;
            wgt_base_d = wgt_base_i;
            k_d        = '0;
            row_d      = '0;
        end else if (row_adv_i) begin
            row_base_d = row_base_q + ADDR_WIDTH'(depth_i);
            k_d        = '0;
            row_d      = row_q + DIM_WIDTH'(1);
        end else if (k_adv_i) begin
            k_d = k_q + DIM_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_base_q <= '0;
            wgt_base_q <= '0;
            k_q        <= '0;
            row_q      <= '0;
        end else begin
            row_base_q <= row_base_d;
            wgt_base_q <= wgt_base_d;
            k_q        <= k_d;
            row_q      <= row_d;
        end
    end

    assign act_addr_o = row_base_q + ADDR_WIDTH'(k_q);
    assign wgt_addr_o = wgt_base_q + ADDR_WIDTH'(k_q);
    assign sparse_o   = k_q[SPARSE_INDEX_WIDTH-1:0];
    assign row_o      = row_q;
    assign k_last_o   = (k_q == depth_i - DIM_WIDTH'(1));
    assign row_last_o = (row_q == rows_i - DIM_WIDTH'(1));

endmodule

// File: rtl/mpu_row_sequencer.sv
// Sequences a job through one MPU a row at a time: fetch K operand pairs,
// stream them as K start pulses, wait for done, hand back one row result.
module mpu_row_sequencer
    import mpu_seq_pkg::*;
#(
    parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
    parameter int SPARSE_INDEX_WIDTH = SPARSE_INDEX_WIDTH_DEF,
    parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
    parameter int DIM_WIDTH          = DIM_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DIM_WIDTH-1:0]          cmd_rows,
    input  logic [DIM_WIDTH-1:0]          cmd_depth,
    input  logic                          cmd_mode,
    input  logic [ADDR_WIDTH-1:0]         cmd_act_base,
    input  logic [ADDR_WIDTH-1:0]         cmd_wgt_base,
    output logic                          act_rd_en,
    output logic [ADDR_WIDTH-1:0]         act_rd_addr,
    input  logic [DATA_WIDTH-1:0]         act_rd_data,
    output logic                          wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]         wgt_rd_addr,
    input  logic [DATA_WIDTH-1:0]         wgt_rd_data,
    output logic [DATA_WIDTH-1:0]         mpu_activation,
    output logic [DATA_WIDTH-1:0]         mpu_weight,
    output logic                          mpu_mode,
    output logic                          mpu_start,
    output logic [SPARSE_INDEX_WIDTH-1:0] mpu_sparse_index,
    input  logic [DATA_WIDTH-1:0]         mpu_result,
    input  logic                          mpu_done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [DIM_WIDTH-1:0]          res_row,
    output logic                          busy,
    output logic                          error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    // Handshakes (cmd_*, res_*): a transfer happens on a clk edge where valid
    // and ready are both high; the valid side holds its payload until then.

    seq_state_e                    state_q;
    job_desc_t                     desc_q;
    logic                          issue_q;
    logic                          start_q;
    logic [SPARSE_INDEX_WIDTH-1:0] sparse_q;
    logic [TMO_W-1:0]              tmo_q;
    logic                          error_q;
    logic [DATA_WIDTH-1:0]         res_data_q;
    logic [DIM_WIDTH-1:0]          res_row_q;

    logic                          load;
    logic                          rd_fire;
    logic                          res_fire;
    logic [ADDR_WIDTH-1:0]         act_addr;
    logic [ADDR_WIDTH-1:0]         wgt_addr;
    logic [SPARSE_INDEX_WIDTH-1:0] k_sparse;
    logic [DIM_WIDTH-1:0]          row;
    logic                          k_last;
    logic                          row_last;

    assign load     = (state_q == ST_IDLE) && cmd_valid;
    assign rd_fire  = (state_q == ST_STREAM) && issue_q;
    assign res_fire = (state_q == ST_RESULT) && res_ready;

    mpu_seq_addr_gen #(
        .ADDR_WIDTH         (ADDR_WIDTH),
        .DIM_WIDTH          (DIM_WIDTH),
        .SPARSE_INDEX_WIDTH (SPARSE_INDEX_WIDTH)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (load),
        .k_adv_i    (rd_fire && !k_last),
        .row_adv_i  (res_fire),
        .act_base_i (cmd_act_base),
        .wgt_base_i (cmd_wgt_base),
        .rows_i     (desc_q.rows),
        .depth_i    (desc_q.depth),
        .act_addr_o (act_addr),
        .wgt_addr_o (wgt_addr),
        .sparse_o   (k_sparse),
        .row_o      (row),
        .k_last_o   (k_last),
        .row_last_o (row_last)
    );

    // STREAM spans K+1 cycles: K read strobes, then one tail cycle in which
    // the last start pulse (lagging its strobe by one) goes out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            desc_q     <= '0;
            issue_q    <= 1'b0;
            start_q    <= 1'b0;
            sparse_q   <= '0;
            tmo_q      <= '0;
            error_q    <= 1'b0;
            res_data_q <= '0;
            res_row_q  <= '0;
        end else begin
            start_q  <= rd_fire;
            sparse_q <= rd_fire ? k_sparse : '0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        desc_q.rows  <= cmd_rows;
                        desc_q.depth <= cmd_depth;
                        desc_q.mode  <= cmd_mode;
                        error_q      <= 1'b0;
                        if ((cmd_rows != '0) && (cmd_depth != '0)) begin
                            state_q <= ST_STREAM;
                            issue_q <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue_q) begin
                        if (k_last) issue_q <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                        tmo_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mpu_done) begin
                        res_data_q <= mpu_result;
                        res_row_q  <= row;
                        state_q    <= ST_RESULT;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        if (row_last) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_STREAM;
                            issue_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign act_rd_en        = rd_fire;
    assign wgt_rd_en        = rd_fire;
    assign act_rd_addr      = rd_fire ? act_addr : '0;
    assign wgt_rd_addr      = rd_fire ? wgt_addr : '0;
    assign mpu_start        = start_q;
    assign mpu_activation   = start_q ? act_rd_data : '0;
    assign mpu_weight       = start_q ? wgt_rd_data : '0;
    assign mpu_sparse_index = sparse_q;
    assign mpu_mode         = busy && desc_q.mode;
    assign res_valid        = (state_q == ST_RESULT);
    assign res_data         = res_data_q;
    assign res_row          = res_row_q;
    assign error            = error_q;

endmodule

// File: tb/tb_mpu_row_sequencer.sv
// Bench for mpu_row_sequencer: table of jobs with expected busy length and
// error, operand RAM and MPU models, and a scoreboard of expected traffic.
module tb_mpu_row_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_rows;
    logic [7:0] cmd_depth;
    logic       cmd_mode;
    logic [9:0] cmd_act_base;
    logic [9:0] cmd_wgt_base;
    logic       act_rd_en;
    logic [9:0] act_rd_addr;
    logic [7:0] act_rd_data;
    logic       wgt_rd_en;
    logic [9:0] wgt_rd_addr;
    logic [7:0] wgt_rd_data;
    logic [7:0] mpu_activation;
    logic [7:0] mpu_weight;
    logic       mpu_mode;
    logic       mpu_start;
    logic [3:0] mpu_sparse_index;
    logic [7:0] mpu_result;
    logic       mpu_done;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_row;
    logic       busy;
    logic       error;

    mpu_row_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
        .cmd_depth(cmd_depth), .cmd_mode(cmd_mode), .cmd_act_base(cmd_act_base),
        .cmd_wgt_base(cmd_wgt_base),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .mpu_activation(mpu_activation), .mpu_weight(mpu_weight), .mpu_mode(mpu_mode),
        .mpu_start(mpu_start), .mpu_sparse_index(mpu_sparse_index),
        .mpu_result(mpu_result), .mpu_done(mpu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .busy(busy), .error(error)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rows;
        int depth;
        int mode;
        int act_base;
        int wgt_base;
        int done_delay;
        int stall;
        int exp_busy;
        int exp_err;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    logic [9:0]  exp_act_q[$];
    logic [9:0]  exp_wgt_q[$];
    logic [3:0]  exp_sp_q[$];
    logic [15:0] exp_res_q[$];

    int         done_delay = 1;
    int         stall_rem  = 0;
    logic       cur_mode   = 1'b0;
    int         tail       = 0;
    bit         armed      = 1'b0;
    bit         start_prev = 1'b0;
    logic [7:0] acc_m      = 8'd0;
    bit         prev_hold  = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic [7:0] prev_row   = 8'd0;

    function automatic logic [7:0] act_f(input logic [9:0] a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] wgt_f(input logic [9:0] a);
        return 8'(a * 13 + 5) ^ 8'(a >> 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // operand buffers: synchronous read, data one cycle after the strobe
    initial begin
        act_rd_data = 8'd0;
        wgt_rd_data = 8'd0;
    end
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_f(act_rd_addr);
        if (wgt_rd_en) wgt_rd_data <= wgt_f(wgt_rd_addr);
    end

    // MPU model, result consumer and scoreboard, all sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            mpu_done   = 1'b0;
            armed      = 1'b0;
            start_prev = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (act_rd_en) begin
                chk("act_strobe_expected", 32'(exp_act_q.size() != 0), 1);
                if (exp_act_q.size() != 0) chk("act_addr", act_rd_addr, exp_act_q.pop_front());
            end
            if (wgt_rd_en) begin
                chk("wgt_strobe_expected", 32'(exp_wgt_q.size() != 0), 1);
                if (exp_wgt_q.size() != 0) chk("wgt_addr", wgt_rd_addr, exp_wgt_q.pop_front());
            end
            if (mpu_start) begin
                chk("start_expected", 32'(exp_sp_q.size() != 0), 1);
                if (exp_sp_q.size() != 0) chk("sparse_index", mpu_sparse_index, exp_sp_q.pop_front());
                chk("mode_in_job", mpu_mode, cur_mode);
                if (!start_prev) acc_m = 8'd0;
                acc_m    = 8'(acc_m + mpu_activation * mpu_weight);
                mpu_done = 1'b0;
                tail     = 0;
                armed    = 1'b1;
            end else begin
                chk("act_zero_no_start", mpu_activation, 0);
                chk("wgt_zero_no_start", mpu_weight, 0);
                if (armed) begin
                    tail++;
                    if (done_delay != 0 && tail == done_delay) begin
                        mpu_done   = 1'b1;
                        mpu_result = acc_m;
                        armed      = 1'b0;
                    end
                end
            end
            start_prev = mpu_start;
            if (cmd_ready) chk("mode_idle", mpu_mode, 0);
            if (res_valid) chk("no_traffic_in_result", {act_rd_en, wgt_rd_en, mpu_start}, 0);
            if (prev_hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, prev_data);
                chk("hold_row", res_row, prev_row);
            end
            res_ready = (stall_rem == 0);
            if (res_valid && stall_rem > 0) stall_rem--;
            if (res_valid && res_ready) begin
                chk("result_expected", 32'(exp_res_q.size() != 0), 1);
                if (exp_res_q.size() != 0) chk("result_row_data", {res_row, res_data}, exp_res_q.pop_front());
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_row  = res_row;
        end
        if (!mpu_done) mpu_result = 8'($urandom_range(0, 255));
    end

    task automatic push_job(input vec_t v);
        logic [7:0] acc;
        logic [9:0] aa;
        logic [9:0] wa;
        if (v.rows != 0 && v.depth != 0) begin
            for (int r = 0; r < v.rows; r++) begin
                acc = 8'd0;
                for (int k = 0; k < v.depth; k++) begin
                    aa = 10'(v.act_base + r * v.depth + k);
                    wa = 10'(v.wgt_base + k);
                    exp_act_q.push_back(aa);
                    exp_wgt_q.push_back(wa);
                    exp_sp_q.push_back(4'(k));
                    acc = 8'(acc + act_f(aa) * wgt_f(wa));
                end
                if (v.exp_err == 0) exp_res_q.push_back({8'(r), acc});
            end
        end
    endtask

    task automatic send_cmd(input vec_t v);
        cur_mode   = v.mode[0];
        done_delay = v.done_delay;
        stall_rem  = v.stall;
        res_ready  = (v.stall == 0);
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_rows     = 8'(v.rows);
        cmd_depth    = 8'(v.depth);
        cmd_mode     = v.mode[0];
        cmd_act_base = 10'(v.act_base);
        cmd_wgt_base = 10'(v.wgt_base);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        push_job(v);
        send_cmd(v);
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_busy_cycles", idx), n, v.exp_busy);
        chk($sformatf("v%0d_error", idx), error, v.exp_err);
        chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
        chk($sformatf("v%0d_res_valid", idx), res_valid, 0);
        chk($sformatf("v%0d_act_left", idx), exp_act_q.size(), 0);
        chk($sformatf("v%0d_start_left", idx), exp_sp_q.size(), 0);
        chk($sformatf("v%0d_res_left", idx), exp_res_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_error"}, error, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_data"}, res_data, 0);
        chk({pfx, "_res_row"}, res_row, 0);
        chk({pfx, "_rd_en"}, {act_rd_en, wgt_rd_en}, 0);
        chk({pfx, "_act_addr"}, act_rd_addr, 0);
        chk({pfx, "_wgt_addr"}, wgt_rd_addr, 0);
        chk({pfx, "_mpu_start"}, mpu_start, 0);
        chk({pfx, "_mpu_operands"}, {mpu_activation, mpu_weight}, 0);
        chk({pfx, "_sparse"}, mpu_sparse_index, 0);
        chk({pfx, "_mpu_mode"}, mpu_mode, 0);
    endtask

    initial begin
        vec_t mid;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_rows     = 8'd0;
        cmd_depth    = 8'd0;
        cmd_mode     = 1'b0;
        cmd_act_base = 10'd0;
        cmd_wgt_base = 10'd0;
        res_ready    = 1'b1;
        mpu_done     = 1'b0;
        mpu_result   = 8'd0;

        // rows depth mode act wgt done_delay stall | exp_busy exp_err
        vecs[0] = '{1, 4, 1, 0,    16,   2, 0,  8, 0};
        vecs[1] = '{3, 2, 0, 8,    0,    1, 0, 15, 0};
        vecs[2] = '{2, 2, 1, 100,  200,  3, 5, 19, 0};
        vecs[3] = '{1, 2, 0, 0,    0,    0, 0, 11, 1};
        vecs[4] = '{2, 3, 1, 50,   60,   1, 0, 12, 0};
        vecs[5] = '{5, 0, 0, 0,    0,    1, 0,  0, 0};
        vecs[6] = '{0, 3, 0, 0,    0,    1, 0,  0, 0};
        vecs[7] = '{1, 20, 0, 300, 900,  2, 0, 24, 0};
        vecs[8] = '{1, 4, 1, 1022, 1021, 1, 0,  7, 0};
        vecs[9] = '{4, 1, 0, 7,    9,    1, 0, 16, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("reset");

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // reset asserted for one cycle in the middle of STREAM
        mid = '{2, 4, 1, 40, 80, 1, 0, 0, 0};
        push_job(mid);
        send_cmd(mid);
        @(negedge clk);
        chk("mid_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_act_q.delete();
        exp_wgt_q.delete();
        exp_sp_q.delete();
        exp_res_q.delete();
        armed      = 1'b0;
        start_prev = 1'b0;
        mpu_done   = 1'b0;
        check_idle_outputs("mid_reset");

        run_vec(10, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
